servo_pwm_gen: RTL and testbench
================================

Name: servo_pwm_gen

Overview:
- Servo PWM generator: consumes the 17-bit duty-count word produced by the position PID loop and drives the servo pulse line.
- Latches duty updates into a shadow register at any time, then applies them only at a period boundary, so no pulse is ever truncated or doubled.
- Sits between the PID controller's duty_out and the servo output pin.
- Hard-clamps every duty value to the servo-safe window.

Parameters:
- PERIOD_CNT, 1000000, clock cycles per PWM period (20 ms at 50 MHz).
- MIN_DUTY, 50000, minimum high-time in cycles (0 degrees).
- MAX_DUTY, 100000, maximum high-time in cycles (180 degrees).
- CENTER_DUTY, 75000, high-time after reset (90 degrees).
- DUTY_W, 17, width of the duty word.
- CNT_W, 20, width of the period counter; must satisfy 2^CNT_W >= PERIOD_CNT.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  run request; low parks the output low.
- duty_in  in  DUTY_W  requested high-time in cycles, unsigned.
- duty_valid  in  1  duty_in is valid this cycle; no backpressure.
- pwm_out  out  1  servo pulse line.
- period_start  out  1  one-cycle pulse on the first cycle of each period.
- duty_applied  out  1  one-cycle pulse, coincident with period_start, when a new shadow value became active.
- clamp_hit  out  1  one-cycle pulse, the cycle after a duty_valid whose duty_in was outside [MIN_DUTY, MAX_DUTY].
- running  out  1  high while state is RUN or STOP.

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to IDLE; counter = 0.
  - active_duty = CENTER_DUTY; shadow empty.
  - All outputs = 0.
  - rst overrides everything, including mid-period: pwm_out is low on the next cycle.
- Input capture:
  - On duty_valid, clamp duty_in to [MIN_DUTY, MAX_DUTY] and write it to shadow; shadow_full is set.
  - Latest value wins; overwriting a full shadow is legal and silent.
  - Capture is allowed in every state.
- Boundary rule:
  - The last cycle of a period is the cycle with counter = PERIOD_CNT-1.
  - At the boundary, if shadow_full, then active_duty <= shadow and shadow_full is cleared.
  - A value captured on the boundary cycle itself is bypassed directly into active_duty for the next period.
  - When a value is applied, duty_applied pulses together with the new period's period_start.
- States:
  - IDLE:
    - counter held at 0; pwm_out = 0; running = 0.
    - enable sampled high moves to RUN; the following cycle is period cycle 0.
    - Any shadow value is applied on entry to RUN, with a duty_applied pulse.
  - RUN:
    - counter increments each cycle and wraps PERIOD_CNT-1 -> 0.
    - pwm_out is high for cycles 0 .. active_duty-1 of each period, i.e. exactly active_duty cycles, with the rising edge aligned to period_start.
    - enable sampled low moves to STOP.
  - STOP:
    - Finishes the current period unchanged.
    - At the boundary, goes to IDLE if enable is low, otherwise resumes RUN without a gap.
    - Never truncates a pulse.
- Outputs are registered; pwm_out and period_start change on the same edge.
- Arithmetic:
  - Counter and compares are unsigned.
  - duty_in is treated as unsigned DUTY_W; values above MAX_DUTY clamp to MAX_DUTY, values below MIN_DUTY clamp to MIN_DUTY.

Test Plan (PERIOD_CNT=20, MIN_DUTY=5, MAX_DUTY=10, CENTER_DUTY=7):
- Reset, then enable=1 with no duty -> period_start every 20 cycles; pwm_out high 7 cycles per period; duty_applied never pulses.
- RUN, duty_in=9 valid at period cycle 3 -> current period keeps 7 high cycles; next period has 9 high cycles; duty_applied pulses with that period's period_start.
- duty_in=3, then duty_in=50, both inside one period -> clamp_hit pulses twice; next period has 10 high cycles (latest wins, clamped to MAX_DUTY).
- duty_in=6 valid exactly on cycle 19 -> the period starting next cycle already has 6 high cycles (bypass).
- enable drops at period cycle 2 with active_duty=8 -> period completes with 8 high cycles, then IDLE: pwm_out stays 0 and running falls after cycle 19.
- rst high at period cycle 4 while pwm_out is high -> next cycle pwm_out=0, state IDLE; re-enable gives 7-cycle pulses (CENTER_DUTY).

Source files
------------

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator.
// Takes duty-count words from the position loop, clamps them to the servo-safe
// window and holds them in a shadow register. A held value becomes the active
// high-time only when a new period starts, so a pulse is never cut short or
// doubled.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | parked: counter held at 0, pwm_out low, waiting for enable
// RUN   | generating periods back to back
// STOP  | enable dropped: finish the current period, then decide
module servo_pwm_gen #(
   parameter int unsigned PERIOD_CNT  = 1000000,
   parameter int unsigned MIN_DUTY    = 50000,
   parameter int unsigned MAX_DUTY    = 100000,
   parameter int unsigned CENTER_DUTY = 75000,
   parameter int unsigned DUTY_W      = 17,
   parameter int unsigned CNT_W       = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [DUTY_W-1:0] duty_in,
   input  logic              duty_valid,
   output logic              pwm_out,
   output logic              period_start,
   output logic              duty_applied,
   output logic              clamp_hit,
   output logic              running
);

   // Compares between counter and duty are done at the wider of the two widths.
   localparam int unsigned CMP_W = (DUTY_W > CNT_W) ? DUTY_W : CNT_W;

   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PERIOD_CNT - 1);
   localparam logic [DUTY_W-1:0] MIN_D    = DUTY_W'(MIN_DUTY);
   localparam logic [DUTY_W-1:0] MAX_D    = DUTY_W'(MAX_DUTY);
   localparam logic [DUTY_W-1:0] CENTER_D = DUTY_W'(CENTER_DUTY);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [DUTY_W-1:0]   active_q;
   logic [DUTY_W-1:0]   shadow_q;
   logic                shadow_full_q;
   logic                pwm_q;
   logic                period_start_q;
   logic                duty_applied_q;
   logic                clamp_hit_q;
   logic                running_q;

   logic [DUTY_W-1:0]   duty_clamped_d;
   logic                duty_oor_d;
   logic                last_cyc_d;
   logic                start_period_d;
   logic                apply_d;
   logic [DUTY_W-1:0]   new_active_d;
   logic [CNT_W-1:0]    cnt_inc_d;
   logic                pwm_cont_d;

   // Clamp the incoming word and work out what the next edge must do.
   always_comb begin
      duty_clamped_d = duty_in;
      duty_oor_d     = 1'b0;
      if (duty_in < MIN_D) begin
         duty_clamped_d = MIN_D;
         duty_oor_d     = 1'b1;
      end else if (duty_in > MAX_D) begin
         duty_clamped_d = MAX_D;
         duty_oor_d     = 1'b1;
      end

      last_cyc_d = (state_q != ST_IDLE) && (cnt_q == LAST_CNT);

      // A new period begins on leaving IDLE, or at a boundary unless STOP
      // is winding down with enable still low.
      start_period_d = ((state_q == ST_IDLE) && enable) ||
                       (last_cyc_d && !((state_q == ST_STOP) && !enable));

      // A word arriving on the start cycle itself bypasses the shadow.
      apply_d      = duty_valid || shadow_full_q;
      new_active_d = active_q;
      if (duty_valid) begin
         new_active_d = duty_clamped_d;
      end else if (shadow_full_q) begin
         new_active_d = shadow_q;
      end

      cnt_inc_d  = cnt_q + CNT_W'(1);
      pwm_cont_d = (CMP_W'(cnt_inc_d) < CMP_W'(active_q));
   end

   // Sequencer: state, period counter, duty registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         active_q       <= CENTER_D;
         shadow_q       <= CENTER_D;
         shadow_full_q  <= 1'b0;
         pwm_q          <= 1'b0;
         period_start_q <= 1'b0;
         duty_applied_q <= 1'b0;
         clamp_hit_q    <= 1'b0;
         running_q      <= 1'b0;
      end else begin
         clamp_hit_q    <= duty_valid && duty_oor_d;
         period_start_q <= 1'b0;
         duty_applied_q <= 1'b0;

         if (duty_valid) begin
            shadow_q      <= duty_clamped_d;
            shadow_full_q <= 1'b1;
         end

         if (start_period_d) begin
            // RUN with enable low at a boundary still owes one full period.
            state_q        <= enable ? ST_RUN : ST_STOP;
            cnt_q          <= '0;
            period_start_q <= 1'b1;
            pwm_q          <= (new_active_d != '0);
            running_q      <= 1'b1;
            if (apply_d) begin
               active_q       <= new_active_d;
               shadow_full_q  <= 1'b0;
               duty_applied_q <= 1'b1;
            end
         end else if ((state_q == ST_IDLE) || last_cyc_d) begin
            // Parked, or STOP finished its period with enable low. Any pending
            // shadow waits and is applied when RUN is next entered.
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pwm_q     <= 1'b0;
            running_q <= 1'b0;
         end else begin
            cnt_q     <= cnt_inc_d;
            pwm_q     <= pwm_cont_d;
            running_q <= 1'b1;
            if ((state_q == ST_RUN) && !enable) begin
               state_q <= ST_STOP;
            end
         end
      end
   end

   assign pwm_out      = pwm_q;
   assign period_start = period_start_q;
   assign duty_applied = duty_applied_q;
   assign clamp_hit    = clamp_hit_q;
   assign running      = running_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen with a short 20-cycle period.
module tb_servo_pwm_gen;

   localparam int PERIOD = 20;
   localparam int MIN_D  = 5;
   localparam int MAX_D  = 10;
   localparam int CENTER = 7;
   localparam int NONE   = -1;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        duty_valid;
   logic [16:0] duty_in;
   logic        pwm_out;
   logic        period_start;
   logic        duty_applied;
   logic        clamp_hit;
   logic        running;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   servo_pwm_gen #(
      .PERIOD_CNT (PERIOD),
      .MIN_DUTY   (MIN_D),
      .MAX_DUTY   (MAX_D),
      .CENTER_DUTY(CENTER),
      .DUTY_W     (17),
      .CNT_W      (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .duty_in     (duty_in),
      .duty_valid  (duty_valid),
      .pwm_out     (pwm_out),
      .period_start(period_start),
      .duty_applied(duty_applied),
      .clamp_hit   (clamp_hit),
      .running     (running)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit oor(input int v);
      return (v < MIN_D) || (v > MAX_D);
   endfunction

   // Entered on period cycle 0; leaves on the cycle after period cycle 19.
   // ia/ib: cycles at which duty words va/vb are presented; drop: cycle at
   // which enable is lowered.
   task automatic run_period(input string tag, input int high, input bit exp_app,
                             input int ia, input int va, input int ib, input int vb,
                             input int drop);
      for (int i = 0; i < PERIOD; i++) begin
         bit exp_clamp;
         exp_clamp = (i > 0) && (((i - 1) == ia && oor(va)) || ((i - 1) == ib && oor(vb)));
         chk($sformatf("%s.pwm@%0d", tag, i), pwm_out, (i < high));
         chk($sformatf("%s.pstart@%0d", tag, i), period_start, (i == 0));
         chk($sformatf("%s.applied@%0d", tag, i), duty_applied, (i == 0) && exp_app);
         chk($sformatf("%s.clamp@%0d", tag, i), clamp_hit, exp_clamp);
         chk($sformatf("%s.running@%0d", tag, i), running, 1);
         duty_valid = 1'b0;
         if (i == ia) begin duty_valid = 1'b1; duty_in = 17'(va); end
         if (i == ib) begin duty_valid = 1'b1; duty_in = 17'(vb); end
         if (i == drop) enable = 1'b0;
         tick;
      end
      duty_valid = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      enable     = 1'b0;
      duty_valid = 1'b0;
      duty_in    = '0;
      tick;
      tick;
      chk("rst.pwm", pwm_out, 0);
      chk("rst.pstart", period_start, 0);
      chk("rst.applied", duty_applied, 0);
      chk("rst.clamp", clamp_hit, 0);
      chk("rst.running", running, 0);
      rst = 1'b0;
      tick;
      chk("idle.running", running, 0);
      chk("idle.pwm", pwm_out, 0);

      // Default centre duty, no updates.
      enable = 1'b1;
      tick;
      run_period("center0", CENTER, 0, NONE, 0, NONE, 0, NONE);
      run_period("center1", CENTER, 0, NONE, 0, NONE, 0, NONE);

      // Mid-period update takes effect next period.
      run_period("upd9_cur", CENTER, 0, 3, 9, NONE, 0, NONE);
      run_period("upd9_new", 9, 1, NONE, 0, NONE, 0, NONE);

      // Two out-of-range words in one period: latest wins, clamped high.
      run_period("clamp_cur", 9, 0, 4, 3, 8, 50, NONE);
      run_period("clamp_new", MAX_D, 1, NONE, 0, NONE, 0, NONE);

      // Word on the last cycle is bypassed into the very next period.
      run_period("bypass_cur", MAX_D, 0, 19, 6, NONE, 0, NONE);
      run_period("bypass_new", 6, 1, 10, 8, NONE, 0, NONE);

      // Enable drops mid-period: period completes with 8, then IDLE.
      run_period("stop", 8, 1, NONE, 0, NONE, 0, 2);
      chk("stop.idle_running", running, 0);
      chk("stop.idle_pwm", pwm_out, 0);
      chk("stop.idle_pstart", period_start, 0);

      // Capture while idle, applied on entry to RUN.
      duty_valid = 1'b1;
      duty_in    = 17'd12;
      tick;
      duty_valid = 1'b0;
      chk("idlecap.clamp", clamp_hit, 1);
      chk("idlecap.pwm", pwm_out, 0);
      chk("idlecap.running", running, 0);
      tick;
      chk("idlecap.clamp_clr", clamp_hit, 0);
      enable = 1'b1;
      tick;
      run_period("idle_apply", MAX_D, 1, NONE, 0, NONE, 0, NONE);

      // Reset in the middle of a high pulse.
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("prerst.pwm@%0d", i), pwm_out, 1);
         tick;
      end
      chk("prerst.pwm@4", pwm_out, 1);
      rst    = 1'b1;
      enable = 1'b0;
      tick;
      chk("midrst.pwm", pwm_out, 0);
      chk("midrst.running", running, 0);
      chk("midrst.pstart", period_start, 0);
      rst = 1'b0;
      tick;
      chk("postrst.running", running, 0);
      chk("postrst.pwm", pwm_out, 0);
      enable = 1'b1;
      tick;
      run_period("post_rst", CENTER, 0, NONE, 0, NONE, 0, NONE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
